instr_exec_unit: RTL and testbench

//   Instruction consumer for mode-1 CPU: takes the 8-bit word from the PC/ROM fetch block,

---
 rtl/instr_exec_unit_pkg.sv | 34 +++
 rtl/exec_mul_seq.sv | 91 +++++++++
 rtl/instr_exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_exec_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_exec_unit_pkg
//   Shared definitions for the mode-1 CPU execute unit and the fetch ROM:
//   instruction field positions, opcode encodings and the execute FSM states.
//   Instruction word layout: [7:5] opcode, [4:0] operand.
//   LDI reuses the operand: [4] register select, [3:0] 4-bit immediate.
// ----------------------------------------------------------------------------
package instr_exec_unit_pkg;

    localparam int INSTR_W    = 8;
    localparam int OPC_MSB    = 7;
    localparam int OPC_LSB    = 5;
    localparam int OPND_MSB   = 4;
    localparam int OPND_W     = OPND_MSB + 1;  // also the MUL iteration count
    localparam int REGSEL_BIT = 4;
    localparam int IMM4_MSB   = 3;
    localparam int IMM4_LSB   = 0;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_EXEC   = 2'd0,
        ST_MUL    = 2'd1,
        ST_HALTED = 2'd2
    } exec_state_e;

endpackage

// File: rtl/exec_mul_seq.sv
// ----------------------------------------------------------------------------
// exec_mul_seq
//   Shift-add multiplier, one partial product per cycle for OPND_W cycles.
//   The final partial product is added combinationally so that `prod` is the
//   complete result in the same cycle `done` is high; the caller writes it
//   back on that edge.
// Ports
//   clock, reset_n : clock and synchronous active-low reset (aborts a run)
//   start          : load operands and begin (ignored while a run is active)
//   stall          : freeze the iteration for this cycle
//   a, b           : multiplicand (DATA_W) and multiplier (OPND_W)
//   done           : high on the last iteration cycle (not while stalled)
//   prod           : DATA_W+OPND_W bit product, valid when done is high
// ----------------------------------------------------------------------------
module exec_mul_seq #(
    parameter int DATA_W = 8,
    parameter int OPND_W = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stall,
    input  logic [DATA_W-1:0]        a,
    input  logic [OPND_W-1:0]        b,
    output logic                     done,
    output logic [DATA_W+OPND_W-1:0] prod
);

    localparam int PROD_W = DATA_W + OPND_W;
    localparam int CNT_W  = $clog2(OPND_W + 1);

    logic              active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [OPND_W-1:0] mplier_q, mplier_d;
    logic [PROD_W-1:0] pp;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        active_d = active_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;

        // Multiplicand shifts left and multiplier right, so bit 0 of the
        // multiplier always gates the current partial product.
        pp   = mplier_q[0] ? mcand_q : '0;
        prod = acc_q + pp;
        done = active_q && !stall && (cnt_q == CNT_W'(OPND_W - 1));

        if (!active_q && start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mcand_d  = PROD_W'(a);
            acc_d    = '0;
            mplier_d = b;
        end else if (active_q && !stall) begin
            acc_d    = prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    // NOTE: only the control bit needs reset; the datapath registers are
    // always loaded by start before they are read, so resetting them buys
    // nothing.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active_q <= 1'b0;
        end else begin
            active_q <= active_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        cnt_q    <= cnt_d;
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/instr_exec_unit.sv
// ----------------------------------------------------------------------------
// instr_exec_unit
//   Execute stage of the mode-1 CPU. Decodes the 8-bit word from the PC/ROM
//   fetch block, executes it on R0/R1 and pulses fetch_ena (Mealy) so the
//   fetch block advances its PC on the same edge the instruction retires.
//   ALU ops take one clock; MUL uses exec_mul_seq and takes OPND_W+1 clocks.
// Ports
//   clock, reset_n  : clock, synchronous active-low reset
//   run             : 1 = execute, 0 = stall (no state change, no fetch_ena)
//   instr_in        : [7:5] opcode, [4:0] operand
//   fetch_ena       : instruction retires this cycle, PC may advance
//   busy            : MUL iterating
//   halted          : HALT has retired; absorbing until reset
//   r0_out, r1_out  : register contents
//   flag_zero       : last ALU result was zero
//   flag_carry      : carry / borrow / MUL overflow of the last arithmetic op
//   retired_cnt     : wrapping count of fetch_ena pulses (EXEC_PERF_CNT_EN)
// Configuration
//   EXEC_PERF_CNT_EN : when defined, adds the retired_cnt port and counter.
// ----------------------------------------------------------------------------
module instr_exec_unit
    import instr_exec_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               fetch_ena,
    output logic               busy,
    output logic               halted,
    output logic [DATA_W-1:0]  r0_out,
    output logic [DATA_W-1:0]  r1_out,
    output logic               flag_zero,
    output logic               flag_carry
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [7:0]         retired_cnt
`endif
);

    exec_state_e               state_q, state_d;
    logic [DATA_W-1:0]         r0_q, r0_d, r1_q, r1_d;
    logic                      zero_q, zero_d, carry_q, carry_d;
    logic                      fetch_d;
    logic                      mul_start, mul_done;
    logic [DATA_W+OPND_W-1:0]  mul_prod;

    logic [2:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0]   sum, diff;

    assign opcode = instr_in[OPC_MSB:OPC_LSB];
    assign imm    = DATA_W'(instr_in[OPND_MSB:0]);
    assign sum    = {1'b0, r0_q} + {1'b0, imm};
    assign diff   = {1'b0, r0_q} - {1'b0, imm};  // MSB is the borrow

    exec_mul_seq #(
        .DATA_W (DATA_W),
        .OPND_W (OPND_W)
    ) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .stall   (!run),
        .a       (r0_q),
        .b       (instr_in[OPND_MSB:0]),
        .done    (mul_done),
        .prod    (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        fetch_d   = 1'b0;
        mul_start = 1'b0;

        if (run) begin
            unique case (state_q)
                ST_EXEC: begin
                    fetch_d = 1'b1;
                    unique case (opcode)
                        OP_ADD: begin
                            r0_d    = sum[DATA_W-1:0];
                            carry_d = sum[DATA_W];
                        end
                        OP_SUB: begin
                            r0_d    = diff[DATA_W-1:0];
                            carry_d = diff[DATA_W];
                        end
                        OP_MUL: begin
                            fetch_d   = 1'b0;
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        OP_AND: begin
                            r0_d    = r0_q & imm;
                            carry_d = 1'b0;
                        end
                        OP_OR: begin
                            r0_d    = r0_q | imm;
                            carry_d = 1'b0;
                        end
                        OP_XOR: begin
                            r0_d    = r0_q ^ imm;
                            carry_d = 1'b0;
                        end
                        OP_LDI: begin
                            if (instr_in[REGSEL_BIT]) begin
                                r1_d = DATA_W'(instr_in[IMM4_MSB:IMM4_LSB]);
                            end else begin
                                r0_d = DATA_W'(instr_in[IMM4_MSB:IMM4_LSB]);
                            end
                        end
                        OP_HALT: begin
                            state_d = ST_HALTED;
                        end
                    endcase
                    // Zero flag tracks ALU results only (ADD..XOR).
                    if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) begin
                        zero_d = (r0_d == '0);
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        fetch_d = 1'b1;
                        r0_d    = mul_prod[DATA_W-1:0];
                        carry_d = |mul_prod[DATA_W+OPND_W-1:DATA_W];
                        zero_d  = (mul_prod[DATA_W-1:0] == '0);
                        state_d = ST_EXEC;
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    state_d = ST_EXEC;
                end
            endcase
        end
    end

    // fetch_ena must stay low during reset even though the FSM is still in
    // its pre-reset state for that cycle.
    assign fetch_ena  = fetch_d && reset_n;
    assign busy       = (state_q == ST_MUL);
    assign halted     = (state_q == ST_HALTED);
    assign r0_out     = r0_q;
    assign r1_out     = r1_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_EXEC;
            r0_q    <= '0;
            r1_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [7:0] retired_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (fetch_ena) begin
            retired_q <= retired_q + 8'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_exec_unit
//   Self-checking bench for instr_exec_unit. A table of single-cycle vectors
//   is streamed through a scoreboard queue; MUL, stall, reset-abort and HALT
//   are exercised by hand-written sequences. Define EXEC_PERF_CNT_EN to also
//   cover the retired-instruction counter.
// ----------------------------------------------------------------------------
module tb_instr_exec_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [7:0] instr_in;
    logic       fetch_ena, busy, halted, flag_zero, flag_carry;
    logic [7:0] r0_out, r1_out;
`ifdef EXEC_PERF_CNT_EN
    logic [7:0] retired_cnt;
`endif

    always #5 clock = ~clock;

    instr_exec_unit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .instr_in   (instr_in),
        .fetch_ena  (fetch_ena),
        .busy       (busy),
        .halted     (halted),
        .r0_out     (r0_out),
        .r1_out     (r1_out),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
`ifdef EXEC_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       run;
        logic [7:0] instr;
        logic       exp_fetch;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
        logic       exp_z;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [7:0] ins, input logic f,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic z, input logic c);
        vec_t v;
        v.run = r; v.instr = ins; v.exp_fetch = f;
        v.exp_r0 = e0; v.exp_r1 = e1; v.exp_z = z; v.exp_c = c;
        vecs.push_back(v);
    endfunction

    // All drives happen 1 time unit after a rising edge; fetch_ena is
    // sampled 1 unit later, registered state 1 unit after the next edge.
    task automatic step(input string name, input logic r, input logic [7:0] ins, input logic exp_fetch);
        run = r;
        instr_in = ins;
        #1;
        check({name, "_fetch"}, fetch_ena, exp_fetch);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        run      = 1'b1;
        instr_in = 8'h05;
        repeat (2) begin
            #1;
            check("rst_fetch", fetch_ena, 0);
            @(posedge clock);
            #1;
        end
        check("rst_r0", r0_out, 0);
        check("rst_r1", r1_out, 0);
        check("rst_zero", flag_zero, 0);
        check("rst_carry", flag_carry, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        reset_n = 1'b1;
    endtask

    // Issue MUL imm with R0 already loaded; optionally drop run for 3 cycles
    // at iteration stall_at (-1 = never).
    task automatic do_mul(input string name, input logic [4:0] imm, input int stall_at,
                          input logic [7:0] exp_r0, input logic exp_c, input logic exp_z);
        int iter;
        bit seen;
        logic [7:0] r0_before;
        r0_before = r0_out;
        step({name, "_issue"}, 1'b1, {3'b010, imm}, 1'b0);
        iter = 0;
        seen = 0;
        while (!seen && iter < 20) begin
            check({name, "_busy"}, busy, 1);
            if (iter == stall_at) begin
                repeat (3) begin
                    run = 1'b0;
                    instr_in = 8'($urandom);
                    #1;
                    check({name, "_stall_fetch"}, fetch_ena, 0);
                    @(posedge clock);
                    #1;
                    check({name, "_stall_busy"}, busy, 1);
                    check({name, "_stall_r0"}, r0_out, r0_before);
                end
            end
            run = 1'b1;
            instr_in = 8'($urandom);  // ignored while iterating
            #1;
            iter++;
            if (fetch_ena === 1'b1) seen = 1;
            @(posedge clock);
            #1;
        end
        check({name, "_busy_cycles"}, iter, 5);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_r0"}, r0_out, exp_r0);
        check({name, "_carry"}, flag_carry, exp_c);
        check({name, "_zero"}, flag_zero, exp_z);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        //  run  instr  fetch r0     r1     z  c
        add(1, 8'hC5, 1, 8'h05, 8'h00, 0, 0);  // LDI R0,5
        add(1, 8'h01, 1, 8'h06, 8'h00, 0, 0);  // ADD 1
        add(1, 8'h01, 1, 8'h07, 8'h00, 0, 0);
        add(1, 8'h01, 1, 8'h08, 8'h00, 0, 0);
        add(0, 8'h05, 0, 8'h08, 8'h00, 0, 0);  // stalled ADD 5
        add(1, 8'hC3, 1, 8'h03, 8'h00, 0, 0);  // LDI R0,3
        add(1, 8'h25, 1, 8'hFE, 8'h00, 0, 1);  // SUB 5 -> borrow
        add(1, 8'hC5, 1, 8'h05, 8'h00, 0, 1);  // LDI keeps flags
        add(1, 8'h25, 1, 8'h00, 8'h00, 1, 0);  // SUB 5 -> zero
        add(1, 8'hDA, 1, 8'h00, 8'h0A, 1, 0);  // LDI R1,10
        add(1, 8'h00, 1, 8'h00, 8'h0A, 1, 0);  // NOP
        add(1, 8'hCF, 1, 8'h0F, 8'h0A, 1, 0);  // LDI R0,15
        add(1, 8'h66, 1, 8'h06, 8'h0A, 0, 0);  // AND 6
        add(1, 8'h91, 1, 8'h17, 8'h0A, 0, 0);  // OR 0x11
        add(1, 8'hB7, 1, 8'h00, 8'h0A, 1, 0);  // XOR 0x17
        add(1, 8'h3F, 1, 8'hE1, 8'h0A, 0, 1);  // SUB 31 from 0
        add(1, 8'h39, 1, 8'hC8, 8'h0A, 0, 0);  // SUB 25 -> 200
        add(1, 8'hD4, 1, 8'hC8, 8'h04, 0, 0);  // LDI R1,4
        add(1, 8'h1F, 1, 8'hE7, 8'h04, 0, 0);  // ADD 31
        add(1, 8'h19, 1, 8'h00, 8'h04, 1, 1);  // ADD 25 -> wraps to 0
        add(1, 8'h21, 1, 8'hFF, 8'h04, 0, 1);  // SUB 1 -> 255
        add(1, 8'h01, 1, 8'h00, 8'h04, 1, 1);  // ADD 1 -> wraps to 0
        add(1, 8'hC0, 1, 8'h00, 8'h04, 1, 1);  // LDI R0,0 keeps flags

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            run      = vecs[i].run;
            instr_in = vecs[i].instr;
            #1;
            check($sformatf("vec%0d_fetch", i), fetch_ena, vecs[i].exp_fetch);
            sb_q.push_back(vecs[i]);
            @(posedge clock);
            #1;
            e = sb_q.pop_front();
            check($sformatf("vec%0d_r0", i), r0_out, e.exp_r0);
            check($sformatf("vec%0d_r1", i), r1_out, e.exp_r1);
            check($sformatf("vec%0d_zero", i), flag_zero, e.exp_z);
            check($sformatf("vec%0d_carry", i), flag_carry, e.exp_c);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // MUL 5*5, then 200*2 with overflow, then 7*0.
        step("ldi5", 1'b1, 8'hC5, 1'b1);
        do_mul("mul5x5", 5'd5, -1, 8'd25, 1'b0, 1'b0);
        step("ldi0", 1'b1, 8'hC0, 1'b1);
        step("sub31", 1'b1, 8'h3F, 1'b1);
        step("sub25", 1'b1, 8'h39, 1'b1);
        check("r0_200", r0_out, 200);
        do_mul("mul200x2", 5'd2, -1, 8'd144, 1'b1, 1'b0);
        step("ldi7", 1'b1, 8'hC7, 1'b1);
        do_mul("mul7x0", 5'd0, -1, 8'd0, 1'b0, 1'b1);

        // MUL with run dropped mid-iteration.
        step("ldi5b", 1'b1, 8'hC5, 1'b1);
        do_mul("mulstall", 5'd5, 2, 8'd25, 1'b0, 1'b0);

        // Reset aborts an in-flight MUL.
        step("ldi5c", 1'b1, 8'hC5, 1'b1);
        step("mulabort_issue", 1'b1, 8'h45, 1'b0);
        step("mulabort_it0", 1'b1, 8'h00, 1'b0);
        step("mulabort_it1", 1'b1, 8'h00, 1'b0);
        reset_n  = 1'b0;
        instr_in = 8'h01;
        #1;
        check("mulabort_rst_fetch", fetch_ena, 0);
        @(posedge clock);
        #1;
        check("mulabort_r0", r0_out, 0);
        check("mulabort_busy", busy, 0);
        reset_n = 1'b1;

        // HALT is absorbing.
        step("ldi_r1", 1'b1, 8'hDA, 1'b1);
        step("halt", 1'b1, 8'hE0, 1'b1);
        check("halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halted%0d", i), 1'($urandom), 8'($urandom), 1'b0);
            check($sformatf("halted%0d_flag", i), halted, 1);
            check($sformatf("halted%0d_r1", i), r1_out, 8'h0A);
            check($sformatf("halted%0d_r0", i), r0_out, 8'h00);
        end
        do_reset();

`ifdef EXEC_PERF_CNT_EN
        check("perf_rst", retired_cnt, 0);
        for (int i = 0; i < 260; i++) begin
            step("perf_op", 1'b1, 8'h01, 1'b1);
        end
        check("perf_wrap", retired_cnt, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
